// File: rtl/ks_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// ks_adder_share_arbiter
//
// One 16-bit Kogge-Stone adder is shared by NUM_REQ requesters (for example
// the add/subtract lanes of an FFT butterfly). A round-robin arbiter grants at
// most one requester per cycle. The granted operands are steered into the
// adder, and the sum, carry-out and owner ID are captured in a single output
// register with valid/ready handshaking. With no consumer stall, the block
// sustains one addition per cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]               per-requester operand valid
//   req_ready  out  [NUM_REQ]               per-requester grant (one-hot or zero)
//   req_a      in   [NUM_REQ*DATA_WIDTH]    packed A operands, lane i at [i*16 +: 16]
//   req_b      in   [NUM_REQ*DATA_WIDTH]    packed B operands, same packing
//   req_cin    in   [NUM_REQ]               per-requester carry-in
//   rsp_valid  out                          result register holds a valid result
//   rsp_ready  in                           consumer accepts the result
//   rsp_id     out  [ID_WIDTH]              requester that owns the result
//   rsp_y      out  [DATA_WIDTH]            sum bits
//   rsp_cout   out                          carry-out
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// kogge_stone_16bit
//
// 16-bit parallel-prefix adder with a log2(16) = 4 level Kogge-Stone
// generate/propagate tree.
//
// Ports:
//   A, B  in   16-bit operands
//   CIN   in   carry-in
//   Y     out  16-bit sum
//   COUT  out  carry-out (bit 16 of A + B + CIN)
// -----------------------------------------------------------------------------
module kogge_stone_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        CIN,
    output logic [15:0] Y,
    output logic        COUT
);

    // Returns {carry_out, sum}. Level k combines each bit with the group that
    // sits 2^k bits below it. After four levels, g[i]/p[i] describe the whole
    // span [i:0]. The carry-in is then folded in once per bit position.
    function automatic logic [16:0] ks_sum(
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        cin
    );
        logic [15:0] half_sum;
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] g_nxt;
        logic [15:0] p_nxt;
        logic [15:0] carry;
        logic        c_out;

        half_sum = a ^ b;
        g        = a & b;
        p        = half_sum;

        for (int lvl = 0; lvl < 4; lvl++) begin
            g_nxt = g;
            p_nxt = p;
            for (int i = (1 << lvl); i < 16; i++) begin
                g_nxt[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
                p_nxt[i] = p[i] & p[i - (1 << lvl)];
            end
            g = g_nxt;
            p = p_nxt;
        end

        // carry[i] is the carry into bit i; it is produced by span [i-1:0].
        carry[0] = cin;
        for (int i = 1; i < 16; i++) begin
            carry[i] = g[i-1] | (p[i-1] & cin);
        end
        c_out = g[15] | (p[15] & cin);

        return {c_out, half_sum ^ carry};
    endfunction

    assign {COUT, Y} = ks_sum(A, B, CIN);

endmodule

module ks_adder_share_arbiter #(
    parameter int NUM_REQ    = 4,                 // number of requesters, >= 2
    parameter int DATA_WIDTH = 16,                // fixed to match the adder
    parameter int ID_WIDTH   = $clog2(NUM_REQ)    // requester ID width
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_y,
    output logic                          rsp_cout
);

    // Round-robin pointer: the requester with the highest priority next.
    logic [ID_WIDTH-1:0]   ptr;

    logic                  can_accept;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    int                    cand;
    logic                  transfer;
    logic [ID_WIDTH-1:0]   ptr_nxt;

    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [DATA_WIDTH-1:0] add_y;
    logic                  add_cout;

    // The output register can take a new result when it is empty, or when its
    // current result leaves this same cycle. That allows a drain and a new
    // grant on one edge, with no bubble.
    assign can_accept = !rsp_valid || rsp_ready;

    // Find the first valid requester at or above the pointer, wrapping around.
    // The candidate index is always reduced into 0..NUM_REQ-1, so the grant
    // never refers to a nonexistent requester.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(cand);
            end
        end
    end

    // Grant decode and operand steering. req_ready is gated by rst_n so that
    // no requester sees an accept while the block is held in reset.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && grant_idx == ID_WIDTH'(i)) begin
                req_ready[i] = can_accept && rst_n;
                add_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                add_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                add_cin      = req_cin[i];
            end
        end
    end

    // req_ready is only raised for a valid requester, so any grant is a transfer.
    assign transfer = |req_ready;

    // The pointer moves to the requester after the winner. It wraps at
    // NUM_REQ, not at 2^ID_WIDTH.
    assign ptr_nxt = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + ID_WIDTH'(1);

    kogge_stone_16bit u_adder (
        .A    (add_a),
        .B    (add_b),
        .CIN  (add_cin),
        .Y    (add_y),
        .COUT (add_cout)
    );

    // Output register and pointer. The data fields are reset as well, so the
    // output after reset is a defined zero and not whatever the flops held.
    // This is a handful of flops, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (transfer) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            rsp_valid <= 1'b1;
            rsp_y     <= add_y;
            rsp_cout  <= add_cout;
            rsp_id    <= grant_idx;
            ptr       <= ptr_nxt;
        end else if (rsp_ready) begin
            // Drain with nothing new: only the valid flag drops; data holds.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ks_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ks_adder_share_arbiter
//
// Directed self-checking bench for ks_adder_share_arbiter (NUM_REQ = 4).
// Inputs change and outputs are sampled on the falling clock edge. The
// combinational req_ready is checked 1 time unit after inputs settle. All
// expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_ks_adder_share_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_y;
    logic             rsp_cout;

    int tests_run    = 0;
    int tests_failed = 0;

    // Round-robin lane operands and expected results.
    logic [15:0] rr_a [4] = '{16'h1111, 16'hFFFF, 16'h1234, 16'h7FFF};
    logic [15:0] rr_b [4] = '{16'h2222, 16'h0000, 16'h4321, 16'h0001};
    logic        rr_ci[4] = '{1'b0,     1'b1,     1'b1,     1'b0};
    logic [15:0] rr_y [4] = '{16'h3333, 16'h0000, 16'h5556, 16'h8000};
    logic        rr_co[4] = '{1'b0,     1'b1,     1'b0,     1'b0};

    // Arithmetic corner vectors on requester 0.
    logic [15:0] ac_a [5] = '{16'hFFFF, 16'h8000, 16'h0005, 16'hFFFE, 16'h0000};
    logic [15:0] ac_b [5] = '{16'hFFFF, 16'h8000, 16'hFFFB, 16'hFFFF, 16'h0000};
    logic        ac_ci[5] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0};
    logic [15:0] ac_y [5] = '{16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000};
    logic        ac_co[5] = '{1'b1,     1'b1,     1'b1,     1'b1,     1'b0};

    ks_adder_share_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id,
                             input logic [15:0] y, input logic cout);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},    32'(rsp_id),    32'(id));
        check({tag, "_y"},     32'(rsp_y),     32'(y));
        check({tag, "_cout"},  32'(rsp_cout),  32'(cout));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // Power-on reset: outputs cleared, no grants even with requests pending.
        repeat (2) @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_valid", 32'(rsp_valid), 32'h0);
        check("reset_y",     32'(rsp_y),     32'h0);
        check("reset_id",    32'(rsp_id),    32'h0);
        check("reset_cout",  32'(rsp_cout),  32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on requester 2.
        drive(2, 16'h0005, 16'h000A, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        check_rsp("single", 2'd2, 16'h000F, 1'b0);

        // Mid-stream reset while a result is pending: cleared asynchronously.
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 32'h0);
        check("midrst_y",     32'(rsp_y),     32'h0);
        check("midrst_id",    32'(rsp_id),    32'h0);
        for (int k = 0; k < 4; k++) drive(k, rr_a[k], rr_b[k], rr_ci[k]);
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        check("midrst_ready", 32'(req_ready), 32'h0);

        // Round-robin: all four valid. After reset the first grant is 0, then
        // 1, 2, 3 on consecutive cycles as each lane drops valid.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rr_ready0", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_rsp($sformatf("rr%0d", k), 2'(k), rr_y[k], rr_co[k]);
            req_valid[k] = 1'b0;
            #1;
            check($sformatf("rr_ready%0d", k + 1), 32'(req_ready),
                  (k < 3) ? (32'd1 << (k + 1)) : 32'd0);
        end

        // Drain with no new transfer: valid drops, data holds.
        @(negedge clk);
        check("drain_valid", 32'(rsp_valid), 32'h0);
        check("drain_y",     32'(rsp_y),     32'h8000);
        check("drain_id",    32'(rsp_id),    32'h3);

        // Backpressure: the result holds and no grant is issued while stalled.
        drive(0, 16'h0001, 16'h0002, 1'b0);
        req_valid = 4'b0001;
        #1;
        check("bp_ready0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        check_rsp("bp_first", 2'd0, 16'h0003, 1'b0);
        rsp_ready = 1'b0;
        drive(1, 16'h00AA, 16'h0055, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("bp_blocked", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_rsp($sformatf("bp_hold%0d", c), 2'd0, 16'h0003, 1'b0);
            #1;
            check($sformatf("bp_blocked%0d", c), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release", 32'(req_ready), 32'b0010);
        @(negedge clk);
        check_rsp("bp_nobubble", 2'd1, 16'h00FF, 1'b0);
        req_valid = '0;

        // Fairness wrap. A grant on requester 2 moves the pointer to 3. Then
        // requesters 3 and 0 both stay valid, and the grants alternate 3, 0, 3.
        drive(2, 16'h0000, 16'h0000, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        check_rsp("wrap_setup", 2'd2, 16'h0000, 1'b0);
        drive(0, 16'h0100, 16'h0200, 1'b0);
        drive(3, 16'hFFFF, 16'hFFFF, 1'b1);
        req_valid = 4'b1001;
        #1;
        check("wrap_ready_a", 32'(req_ready), 32'b1000);
        @(negedge clk);
        check_rsp("wrap_r3", 2'd3, 16'hFFFF, 1'b1);
        #1;
        check("wrap_ready_b", 32'(req_ready), 32'b0001);
        @(negedge clk);
        check_rsp("wrap_r0", 2'd0, 16'h0300, 1'b0);
        #1;
        check("wrap_ready_c", 32'(req_ready), 32'b1000);
        @(negedge clk);
        check_rsp("wrap_r3b", 2'd3, 16'hFFFF, 1'b1);
        req_valid = '0;
        @(negedge clk);
        check("wrap_drain", 32'(rsp_valid), 32'h0);

        // Arithmetic corners, back to back through requester 0.
        req_valid = 4'b0001;
        for (int v = 0; v < 5; v++) begin
            drive(0, ac_a[v], ac_b[v], ac_ci[v]);
            #1;
            check($sformatf("arith%0d_ready", v), 32'(req_ready), 32'b0001);
            @(negedge clk);
            check_rsp($sformatf("arith%0d", v), 2'd0, ac_y[v], ac_co[v]);
        end
        req_valid = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
